// File: rtl/csr_trap_sequencer.sv
// Machine-mode trap/return sequencer. Owns the CSR file ports while a
// timer-interrupt trap entry or an MRET is being carried out, and hands
// them back to the core in IDLE.
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | core owns CSR ports; watch for MRET / pending irq
// T_RD    | trap: read mstatus into mstatus_q
// T_SAVE  | trap: write mepc (port 1) and updated mstatus (port 2)
// T_VEC   | trap: write mcause, read mtvec, form redirect target
// M_RD    | mret: read mstatus into mstatus_q
// M_RET   | mret: write restored mstatus, read mepc as redirect
module csr_trap_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_instr_boundary,
  input  logic                  i_mret,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic                  i_mie_mstatus,
  input  logic                  i_mtip_mip,
  input  logic                  i_mtie_mie,
  input  logic                  i_core_we,
  input  logic [ADDR_WIDTH-1:0] i_core_waddr,
  input  logic [DATA_WIDTH-1:0] i_core_wdata,
  input  logic [ADDR_WIDTH-1:0] i_core_raddr,
  input  logic [DATA_WIDTH-1:0] i_csr_rdata,
  output logic [ADDR_WIDTH-1:0] o_csr_raddr,
  output logic                  o_csr_we_1,
  output logic [ADDR_WIDTH-1:0] o_csr_waddr_1,
  output logic [DATA_WIDTH-1:0] o_csr_wdata_1,
  output logic                  o_csr_we_2,
  output logic [ADDR_WIDTH-1:0] o_csr_waddr_2,
  output logic [DATA_WIDTH-1:0] o_csr_wdata_2,
  output logic [DATA_WIDTH-1:0] o_core_rdata,
  output logic                  o_busy,
  output logic                  o_redirect_valid,
  output logic [DATA_WIDTH-1:0] o_redirect_pc
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_T_RD   = 3'd1;
  localparam logic [2:0] S_T_SAVE = 3'd2;
  localparam logic [2:0] S_T_VEC  = 3'd3;
  localparam logic [2:0] S_M_RD   = 3'd4;
  localparam logic [2:0] S_M_RET  = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] A_MSTATUS = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_MTVEC   = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_MCAUSE  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_MEPC    = ADDR_WIDTH'(5);

  // Interrupt bit set, machine timer interrupt (cause 7).
  localparam logic [DATA_WIDTH-1:0] MCAUSE_MTI = {1'b1, {(DATA_WIDTH-4){1'b0}}, 3'd7};

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [DATA_WIDTH-1:0] r_pc_q;
  logic [DATA_WIDTH-1:0] r_mstatus_q;
  logic                  r_redirect_valid;
  logic [DATA_WIDTH-1:0] r_redirect_pc;

  logic                  w_irq;
  logic                  w_take_mret;
  logic                  w_take_trap;
  logic [DATA_WIDTH-1:0] w_mtvec_base;
  logic [DATA_WIDTH-1:0] w_trap_target;

  assign w_irq       = i_mie_mstatus & i_mtip_mip & i_mtie_mie;
  assign w_take_mret = i_instr_boundary & i_mret;
  assign w_take_trap = i_instr_boundary & ~i_mret & w_irq;

  // Vectored mode jumps to base + 4*cause; the add wraps at DATA_WIDTH.
  assign w_mtvec_base  = i_csr_rdata & ~DATA_WIDTH'(3);
  assign w_trap_target = (i_csr_rdata[1:0] == 2'b01) ? w_mtvec_base + DATA_WIDTH'(28)
                                                     : w_mtvec_base;

  assign o_core_rdata     = i_csr_rdata;
  assign o_busy           = (r_state != S_IDLE);
  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;

  // Next-state and CSR port arbitration/steering.
  always_comb begin
    w_next        = r_state;
    o_csr_raddr   = A_MSTATUS;
    o_csr_we_1    = 1'b0;
    o_csr_waddr_1 = A_MSTATUS;
    o_csr_wdata_1 = '0;
    o_csr_we_2    = 1'b0;
    o_csr_waddr_2 = A_MSTATUS;
    o_csr_wdata_2 = '0;
    case (r_state)
      S_IDLE: begin
        o_csr_raddr   = i_core_raddr;
        o_csr_we_1    = i_core_we;
        o_csr_waddr_1 = i_core_waddr;
        o_csr_wdata_1 = i_core_wdata;
        if (w_take_mret)      w_next = S_M_RD;
        else if (w_take_trap) w_next = S_T_RD;
      end
      S_T_RD: begin
        o_csr_raddr = A_MSTATUS;
        w_next      = S_T_SAVE;
      end
      S_T_SAVE: begin
        o_csr_we_1       = 1'b1;
        o_csr_waddr_1    = A_MEPC;
        o_csr_wdata_1    = r_pc_q;
        o_csr_we_2       = 1'b1;
        o_csr_waddr_2    = A_MSTATUS;
        o_csr_wdata_2    = r_mstatus_q;
        o_csr_wdata_2[7] = r_mstatus_q[3];
        o_csr_wdata_2[3] = 1'b0;
        w_next           = S_T_VEC;
      end
      S_T_VEC: begin
        o_csr_we_1    = 1'b1;
        o_csr_waddr_1 = A_MCAUSE;
        o_csr_wdata_1 = MCAUSE_MTI;
        o_csr_raddr   = A_MTVEC;
        w_next        = S_IDLE;
      end
      S_M_RD: begin
        o_csr_raddr = A_MSTATUS;
        w_next      = S_M_RET;
      end
      S_M_RET: begin
        o_csr_we_2       = 1'b1;
        o_csr_waddr_2    = A_MSTATUS;
        o_csr_wdata_2    = r_mstatus_q;
        o_csr_wdata_2[3] = r_mstatus_q[7];
        o_csr_wdata_2[7] = 1'b1;
        o_csr_raddr      = A_MEPC;
        w_next           = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, captured PC/mstatus and the registered redirect.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state          <= S_IDLE;
      r_pc_q           <= '0;
      r_mstatus_q      <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_state          <= w_next;
      r_redirect_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take_trap) r_pc_q <= i_pc;
        end
        S_T_RD, S_M_RD: r_mstatus_q <= i_csr_rdata;
        S_T_VEC: begin
          r_redirect_valid <= 1'b1;
          r_redirect_pc    <= w_trap_target;
        end
        S_M_RET: begin
          r_redirect_valid <= 1'b1;
          r_redirect_pc    <= i_csr_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Bench for csr_trap_sequencer: an 8-entry CSR file lives here, the
// sequencer drives it, and each trap/MRET outcome is predicted from the
// architectural rules (what the CSRs and the PC should look like after).
module tb_csr_trap_sequencer;

  logic        clk = 1'b0;
  logic        arst;
  logic        i_instr_boundary;
  logic        i_mret;
  logic [63:0] i_pc;
  logic        i_core_we;
  logic [2:0]  i_core_waddr;
  logic [63:0] i_core_wdata;
  logic [2:0]  i_core_raddr;
  logic [63:0] i_csr_rdata;
  logic [2:0]  o_csr_raddr;
  logic        o_csr_we_1;
  logic [2:0]  o_csr_waddr_1;
  logic [63:0] o_csr_wdata_1;
  logic        o_csr_we_2;
  logic [2:0]  o_csr_waddr_2;
  logic [63:0] o_csr_wdata_2;
  logic [63:0] o_core_rdata;
  logic        o_busy;
  logic        o_redirect_valid;
  logic [63:0] o_redirect_pc;

  logic [63:0] mem [8];
  logic        w_mie, w_mtip, w_mtie;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] last_rpc;

  always #5 clk = ~clk;

  assign i_csr_rdata = mem[o_csr_raddr];
  assign w_mie  = mem[0][3];
  assign w_mtie = mem[2][7];
  assign w_mtip = mem[6][7];

  // CSR file: two synchronous write ports, combinational read.
  always @(posedge clk) begin
    if (o_csr_we_1) mem[o_csr_waddr_1] <= o_csr_wdata_1;
    if (o_csr_we_2) mem[o_csr_waddr_2] <= o_csr_wdata_2;
  end

  csr_trap_sequencer #(.DATA_WIDTH(64), .ADDR_WIDTH(3)) dut (
    .clk              (clk),
    .arst             (arst),
    .i_instr_boundary (i_instr_boundary),
    .i_mret           (i_mret),
    .i_pc             (i_pc),
    .i_mie_mstatus    (w_mie),
    .i_mtip_mip       (w_mtip),
    .i_mtie_mie       (w_mtie),
    .i_core_we        (i_core_we),
    .i_core_waddr     (i_core_waddr),
    .i_core_wdata     (i_core_wdata),
    .i_core_raddr     (i_core_raddr),
    .i_csr_rdata      (i_csr_rdata),
    .o_csr_raddr      (o_csr_raddr),
    .o_csr_we_1       (o_csr_we_1),
    .o_csr_waddr_1    (o_csr_waddr_1),
    .o_csr_wdata_1    (o_csr_wdata_1),
    .o_csr_we_2       (o_csr_we_2),
    .o_csr_waddr_2    (o_csr_waddr_2),
    .o_csr_wdata_2    (o_csr_wdata_2),
    .o_core_rdata     (o_core_rdata),
    .o_busy           (o_busy),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Core-side CSR write through port 1 while the sequencer is idle.
  task automatic csr_write(input logic [2:0] addr, input logic [63:0] data);
    i_core_we    = 1'b1;
    i_core_waddr = addr;
    i_core_wdata = data;
    @(posedge clk); #1;
    i_core_we    = 1'b0;
  endtask

  // Present one instruction boundary and check the whole outcome.
  // wr_cycle > 0 issues a core write to mie in that cycle after accept.
  task automatic run_seq(input bit mret, input logic [63:0] pc, input int wr_cycle);
    logic [63:0] exp_mem [8];
    logic [63:0] ms, tv, exp_pc, got_pc;
    int          kind, lat, got_lat, n_busy, n_valid;
    bit          irq;
    for (int i = 0; i < 8; i++) exp_mem[i] = mem[i];
    ms     = mem[0];
    tv     = mem[3];
    irq    = mem[0][3] & mem[2][7] & mem[6][7];
    kind   = mret ? 2 : (irq ? 1 : 0);
    exp_pc = last_rpc;
    lat    = 0;
    if (kind == 1) begin
      exp_mem[5]    = pc;
      exp_mem[4]    = 64'h8000_0000_0000_0007;
      exp_mem[0]    = ms;
      exp_mem[0][7] = ms[3];
      exp_mem[0][3] = 1'b0;
      exp_pc        = (tv[1:0] == 2'b01) ? (tv & ~64'h3) + 64'd28 : (tv & ~64'h3);
      lat           = 4;
    end else if (kind == 2) begin
      exp_mem[0]    = ms;
      exp_mem[0][3] = ms[7];
      exp_mem[0][7] = 1'b1;
      exp_pc        = mem[5];
      lat           = 3;
    end
    i_instr_boundary = 1'b1;
    i_mret           = mret;
    i_pc             = pc;
    @(posedge clk); #1;
    i_instr_boundary = 1'b0;
    i_mret           = 1'b0;
    i_pc             = {$urandom, $urandom};
    got_lat = 0; n_busy = 0; n_valid = 0; got_pc = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (o_busy) n_busy++;
      if (o_redirect_valid) begin
        n_valid++;
        if (got_lat == 0) begin
          got_lat = k;
          got_pc  = o_redirect_pc;
        end
      end
      @(posedge clk); #1;
      i_core_we    = (k + 1 == wr_cycle);
      i_core_waddr = 3'd2;
      i_core_wdata = 64'hDEAD_0000_0000_BEEF;
    end
    i_core_we = 1'b0;
    chk("latency", 64'(got_lat), 64'(lat));
    chk("pulses", 64'(n_valid), (kind != 0) ? 64'd1 : 64'd0);
    chk("busy_cycles", 64'(n_busy), (kind != 0) ? 64'(lat - 1) : 64'd0);
    if (kind != 0) chk("redirect_pc", got_pc, exp_pc);
    chk("redirect_hold", o_redirect_pc, exp_pc);
    for (int i = 0; i < 8; i++) chk($sformatf("csr%0d", i), mem[i], exp_mem[i]);
    last_rpc = exp_pc;
  endtask

  initial begin
    logic [63:0] snap5, r;
    arst = 1'b1;
    i_instr_boundary = 1'b0; i_mret = 1'b0; i_pc = '0;
    i_core_we = 1'b0; i_core_waddr = '0; i_core_wdata = '0; i_core_raddr = '0;
    last_rpc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_valid", 64'(o_redirect_valid), 64'd0);
    chk("rst_rpc", o_redirect_pc, 64'd0);
    chk("rst_we1", 64'(o_csr_we_1), 64'd0);
    chk("rst_we2", 64'(o_csr_we_2), 64'd0);
    arst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) csr_write(3'(i), 64'd0);

    // Timer trap, direct mode.
    csr_write(3'd0, 64'h8);
    csr_write(3'd2, 64'h80);
    csr_write(3'd6, 64'h80);
    csr_write(3'd3, 64'h8000);
    run_seq(1'b0, 64'h1000, 0);
    chk("t1_mepc", mem[5], 64'h1000);
    chk("t1_mstatus", mem[0], 64'h80);
    chk("t1_mcause", mem[4], 64'h8000_0000_0000_0007);
    chk("t1_rpc", o_redirect_pc, 64'h8000);

    // Vectored trap.
    csr_write(3'd0, 64'h8);
    csr_write(3'd3, 64'h8001);
    run_seq(1'b0, 64'h1000, 0);
    chk("t2_rpc", o_redirect_pc, 64'h801C);

    // Vectored target wraps around the top of the address space.
    csr_write(3'd0, 64'h8);
    csr_write(3'd3, 64'hFFFF_FFFF_FFFF_FFF1);
    run_seq(1'b0, 64'h1100, 0);
    chk("wrap_rpc", o_redirect_pc, 64'hC);

    // MRET.
    csr_write(3'd0, 64'h80);
    csr_write(3'd5, 64'h1004);
    run_seq(1'b1, 64'h7777, 0);
    chk("m_mstatus", mem[0], 64'h88);
    chk("m_rpc", o_redirect_pc, 64'h1004);

    // MRET and irq together: MRET first, then trap at next boundary.
    csr_write(3'd5, 64'h2000);
    run_seq(1'b1, 64'h2222, 0);
    chk("pri_rpc", o_redirect_pc, 64'h2000);
    run_seq(1'b0, 64'h3000, 0);
    chk("pri_mepc", mem[5], 64'h3000);

    // Masked irq: no trap; core writes and reads pass through.
    csr_write(3'd0, 64'h0);
    run_seq(1'b0, 64'h4000, 0);
    csr_write(3'd2, 64'hA5A5);
    i_core_raddr = 3'd2;
    #1;
    chk("pass_wr", mem[2], 64'hA5A5);
    chk("pass_rd", o_core_rdata, 64'hA5A5);
    csr_write(3'd2, 64'h80);

    // Core write during T_SAVE is dropped.
    csr_write(3'd0, 64'h8);
    run_seq(1'b0, 64'h5000, 2);

    // Reset while in T_SAVE aborts without a redirect.
    csr_write(3'd0, 64'h8);
    csr_write(3'd3, 64'h9000);
    snap5 = mem[5];
    i_instr_boundary = 1'b1; i_pc = 64'h6000;
    @(posedge clk); #1;
    i_instr_boundary = 1'b0;
    @(posedge clk); #1;
    arst = 1'b1;
    #1;
    chk("rs_busy", 64'(o_busy), 64'd0);
    chk("rs_valid", 64'(o_redirect_valid), 64'd0);
    chk("rs_rpc", o_redirect_pc, 64'd0);
    chk("rs_we2", 64'(o_csr_we_2), 64'd0);
    @(posedge clk); #1;
    arst = 1'b0;
    last_rpc = '0;
    begin
      int nv = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (o_redirect_valid) nv++;
      end
      chk("rs_nopulse", 64'(nv), 64'd0);
    end
    @(posedge clk); #1;
    chk("rs_mepc", mem[5], snap5);
    run_seq(1'b0, 64'h6100, 0);
    chk("rs_after_rpc", o_redirect_pc, 64'h9000);

    // Randomized traps / returns.
    for (int it = 0; it < 24; it++) begin
      r = {$urandom, $urandom};
      csr_write(3'd0, r);
      r = {$urandom, $urandom};
      r[7] = ($urandom_range(0, 4) != 0);
      csr_write(3'd2, r);
      r = {$urandom, $urandom};
      r[7] = ($urandom_range(0, 4) != 0);
      csr_write(3'd6, r);
      csr_write(3'd3, {$urandom, $urandom});
      csr_write(3'd5, {$urandom, $urandom});
      run_seq($urandom_range(0, 2) == 0, {$urandom, $urandom}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_trap_sequencer.md
Name: csr_trap_sequencer

Overview:
- Machine-mode trap/return controller sitting between the core datapath and the 8-entry CSR file.
- Takes a pending timer interrupt at an instruction boundary, or executes MRET, as a fixed multi-cycle CSR sequence:
  - Trap entry: save mepc, mcause and mstatus, then fetch mtvec.
  - MRET: restore mstatus, then fetch mepc.
- Arbitrates the CSR file ports: the core owns them in IDLE, the sequencer owns them otherwise.
- Outputs one PC redirect per sequence.

Parameters:
- DATA_WIDTH, 64, CSR/PC width.
- ADDR_WIDTH, 3, CSR file address width. Map: 0 mstatus, 2 mie, 3 mtvec, 4 mcause, 5 mepc, 6 mip.

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous active-high reset.
- i_instr_boundary  in  1  core is at an instruction boundary and can accept a trap/return.
- i_mret  in  1  instruction at the boundary is MRET (qualified by i_instr_boundary).
- i_pc  in  DATA_WIDTH  PC to save into mepc on trap.
- i_mie_mstatus  in  1  mstatus.MIE from the CSR file.
- i_mtip_mip  in  1  mip.MTIP from the CSR file.
- i_mtie_mie  in  1  mie.MTIE from the CSR file.
- i_core_we  in  1  core CSR write request.
- i_core_waddr  in  ADDR_WIDTH  core CSR write address.
- i_core_wdata  in  DATA_WIDTH  core CSR write data.
- i_core_raddr  in  ADDR_WIDTH  core CSR read address.
- i_csr_rdata  in  DATA_WIDTH  CSR file read data (combinational).
- o_csr_raddr  out  ADDR_WIDTH  CSR file read address.
- o_csr_we_1  out  1  CSR file write port 1 enable.
- o_csr_waddr_1  out  ADDR_WIDTH  CSR file write port 1 address.
- o_csr_wdata_1  out  DATA_WIDTH  CSR file write port 1 data.
- o_csr_we_2  out  1  CSR file write port 2 enable.
- o_csr_waddr_2  out  ADDR_WIDTH  CSR file write port 2 address.
- o_csr_wdata_2  out  DATA_WIDTH  CSR file write port 2 data.
- o_core_rdata  out  DATA_WIDTH  i_csr_rdata returned to the core.
- o_busy  out  1  sequence in progress; core must stall.
- o_redirect_valid  out  1  one-cycle pulse; PC must load o_redirect_pc.
- o_redirect_pc  out  DATA_WIDTH  redirect target.

Behaviour:
- Reset is async. On reset: state IDLE; all registers cleared; o_busy=0, o_redirect_valid=0, o_redirect_pc=0; all write enables 0.
- Reset mid-sequence aborts it. Partial CSR writes already performed are not undone.

Interrupt pending:
- irq = i_mie_mstatus & i_mtip_mip & i_mtie_mie.

States: IDLE, T_RD, T_SAVE, T_VEC, M_RD, M_RET.

IDLE:
- Port 1 passes through from the core: o_csr_we_1=i_core_we, o_csr_waddr_1=i_core_waddr, o_csr_wdata_1=i_core_wdata.
- o_csr_raddr=i_core_raddr.
- Port 2 disabled.
- If i_instr_boundary & i_mret: go to M_RD. MRET has priority over irq; irq is re-evaluated after returning to IDLE.
- Else if i_instr_boundary & irq: latch i_pc into pc_q and go to T_RD.
- o_busy=0.

All non-IDLE states:
- o_busy=1.
- Core write inputs are ignored/dropped.
- o_core_rdata still mirrors i_csr_rdata.

T_RD:
- Read addr 0; latch mstatus_q.
- Go to T_SAVE.

T_SAVE:
- Port 1 writes addr 5 (mepc) with pc_q.
- Port 2 writes addr 0 with mstatus_q, where bit7 (MPIE) = mstatus_q[3] and bit3 (MIE) = 0.
- Go to T_VEC.

T_VEC:
- Port 1 writes addr 4 (mcause) with {1'b1, zeros, 7}, i.e. 0x8000_0000_0000_0007 at 64 bits.
- Read addr 3 (mtvec). base = mtvec with bits[1:0] cleared.
- If mtvec[1:0]==2'b01, target = base+28 (vectored, cause 7); otherwise target = base.
- Register o_redirect_pc=target and o_redirect_valid=1 for the cycle after T_VEC.
- Go to IDLE.

M_RD:
- Read addr 0; latch mstatus_q.
- Go to M_RET.

M_RET:
- Port 2 writes addr 0 with mstatus_q, where MIE (bit3) = mstatus_q[7] and MPIE (bit7) = 1.
- Read addr 5 (mepc); register it into o_redirect_pc with o_redirect_valid=1 in the next cycle.
- Go to IDLE.

Latency and timing:
- Trap: accept at cycle N; redirect pulse at N+4.
- MRET: accept at cycle N; redirect pulse at N+3.
- o_redirect_valid is exactly one cycle. o_redirect_pc holds its value until the next redirect.
- A new sequence may be accepted in the same cycle the redirect pulse is high (state is IDLE then).

Arithmetic:
- base+28 wraps modulo 2^DATA_WIDTH.
- Unchanged mstatus bits are written back from mstatus_q.

Test Plan:
- Timer trap: reset; MIE=1, MTIE=1, MTIP=1; boundary with i_pc=0x1000; mtvec=0x8000 -> writes mepc=0x1000, mstatus MIE=0/MPIE=1, mcause=0x8000000000000007; redirect 0x8000 exactly 4 cycles after accept; o_busy high for 3 cycles.
- Vectored trap: mtvec=0x8001 -> redirect 0x801C.
- MRET: mstatus=0x80, mepc=0x1004, boundary+i_mret -> mstatus=0x88; redirect 0x1004 three cycles later.
- Priority: i_mret and irq asserted together -> MRET sequence runs first; trap is taken at the next boundary, with mepc = PC at that boundary.
- Masking/arbitration: irq with MIE=0 -> no trap and core writes pass through. A core write issued while busy (T_SAVE) -> dropped; CSR file shows only sequencer writes.
- Reset during T_SAVE -> state IDLE, o_busy=0, no redirect pulse; a fresh trap afterwards completes normally.
